// File: rtl/sbox_sched_pkg.sv
// Shared types and constants for the masked S-box scheduler.
package sbox_sched_pkg;

   // Width of one unshared S-box word (four byte lanes)
   localparam int unsigned WORD_W = 32;

   // Default S-box pipeline depth, shared with the S-box wrapper
   localparam int unsigned SBOX_LATENCY = 4;

   typedef enum logic {
      OWN_ST  = 1'b0,
      OWN_KEY = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } tag_t;

endpackage

// File: rtl/sbox_tag_pipe.sv
// Enable-gated tag shift register that mirrors the S-box pipeline depth.
module sbox_tag_pipe
   import sbox_sched_pkg::*;
#(
   parameter int unsigned LATENCY = SBOX_LATENCY
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  tag_t head_i,
   output tag_t tail_o,
   output logic any_valid_c
);

   tag_t tags_q [LATENCY];

   // Shift tags one stage per enabled cycle; reset drops all in-flight ownership
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(LATENCY); i++) begin
            tags_q[i] <= '0;
         end
      end else if (en_i) begin
         tags_q[0] <= head_i;
         for (int i = 1; i < int'(LATENCY); i++) begin
            tags_q[i] <= tags_q[i-1];
         end
      end
   end

   assign tail_o = tags_q[LATENCY-1];

   // Any stage holding a live result
   always_comb begin
      any_valid_c = 1'b0;
      for (int i = 0; i < int'(LATENCY); i++) begin
         any_valid_c = any_valid_c | tags_q[i].valid;
      end
   end

endmodule

// File: rtl/sbox_share_sched.sv
// Time-shares one masked S-box pipeline between the state-column and
// key-schedule requesters; advances only when fresh randomness is present.
// Optional: define SBOX_SCHED_RR_EN for round-robin on contention
// (otherwise the key path has fixed priority).
module sbox_share_sched
   import sbox_sched_pkg::*;
#(
   parameter int unsigned d       = 2,
   parameter int unsigned LATENCY = SBOX_LATENCY
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  st_in_valid,
   output logic                  st_in_ready,
   input  logic [WORD_W*d-1:0]   st_in_data,
   input  logic                  key_in_valid,
   output logic                  key_in_ready,
   input  logic [WORD_W*d-1:0]   key_in_data,
   input  logic                  rnd_valid,
   output logic                  rnd_ready,
   output logic                  sb_en,
   output logic [WORD_W*d-1:0]   sb_in,
   input  logic [WORD_W*d-1:0]   sb_out,
   output logic                  st_out_valid,
   output logic                  key_out_valid,
   output logic [WORD_W*d-1:0]   out_data,
   output logic                  busy
);

   localparam int unsigned DW    = WORD_W * d;
   localparam int unsigned CNT_W = $clog2(LATENCY + 1);

   logic             en_c;
   logic             grant_st_c;
   logic             grant_key_c;
   logic             grant_any_c;
   logic             result_c;
   tag_t             head_c;
   tag_t             tail_c;
   logic             tags_any_c;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign en_c        = rnd_valid;
   assign grant_any_c = grant_st_c | grant_key_c;

`ifdef SBOX_SCHED_RR_EN
   owner_e ptr_q;
   owner_e ptr_d;

   // Arbitration: the pointer picks the winner only when both paths request
   always_comb begin
      grant_st_c  = 1'b0;
      grant_key_c = 1'b0;
      ptr_d       = ptr_q;
      if (en_c) begin
         if (st_in_valid && key_in_valid) begin
            grant_st_c  = (ptr_q == OWN_ST);
            grant_key_c = (ptr_q == OWN_KEY);
            ptr_d       = (ptr_q == OWN_ST) ? OWN_KEY : OWN_ST;
         end else begin
            grant_st_c  = st_in_valid;
            grant_key_c = key_in_valid;
         end
      end
   end

   // Round-robin pointer, moves only after a contended grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= OWN_ST;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // Arbitration: key path always wins on contention
   always_comb begin
      grant_st_c  = 1'b0;
      grant_key_c = 1'b0;
      if (en_c) begin
         grant_key_c = key_in_valid;
         grant_st_c  = st_in_valid & ~key_in_valid;
      end
   end
`endif

   // Handshake, S-box input mux and head tag; data passes only with a grant
   always_comb begin
      st_in_ready  = grant_st_c;
      key_in_ready = grant_key_c;
      rnd_ready    = en_c;
      sb_en        = en_c;
      sb_in        = '0;
      head_c       = '0;
      if (grant_key_c) begin
         sb_in  = key_in_data;
      end else if (grant_st_c) begin
         sb_in  = st_in_data;
      end
      head_c.valid = grant_any_c;
      head_c.owner = grant_key_c ? OWN_KEY : OWN_ST;
   end

   sbox_tag_pipe #(
      .LATENCY (LATENCY)
   ) u_tag_pipe (
      .clk         (clk),
      .rst         (rst),
      .en_i        (en_c),
      .head_i      (head_c),
      .tail_o      (tail_c),
      .any_valid_c (tags_any_c)
   );

   // Result pulse towards the owning path, data straight from the S-box
   always_comb begin
      result_c      = tail_c.valid & en_c;
      st_out_valid  = result_c & (tail_c.owner == OWN_ST);
      key_out_valid = result_c & (tail_c.owner == OWN_KEY);
      out_data      = DW'(sb_out);
      busy          = tags_any_c;
   end

   // In-flight count next state
   always_comb begin
      cnt_d = cnt_q;
      case ({grant_any_c, result_c})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // In-flight counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Tag occupancy and counter must always agree
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (busy == (cnt_q != '0));
         assert (cnt_q <= CNT_W'(LATENCY));
      end
   end

endmodule

// File: tb/tb_sbox_share_sched.sv
// Randomised scoreboard bench for sbox_share_sched. Reference model follows
// the arbitration/latency rules directly; honours SBOX_SCHED_RR_EN.
module tb_sbox_share_sched;

   localparam int unsigned D       = 2;
   localparam int unsigned LATENCY = 4;
   localparam int unsigned DW      = 32 * D;
   localparam logic [DW-1:0] MASKC = 64'hA5C3_0F1E_5A3C_F0E1;

   typedef struct {
      int          owner;   // 0 = state, 1 = key
      logic [DW-1:0] data;
      int          due;     // enabled-cycle index of the expected pulse
   } exp_t;

   logic          clk;
   logic          rst;
   logic          st_in_valid, key_in_valid;
   logic          st_in_ready, key_in_ready;
   logic [DW-1:0] st_in_data, key_in_data;
   logic          rnd_valid, rnd_ready, sb_en;
   logic [DW-1:0] sb_in, sb_out, out_data;
   logic          st_out_valid, key_out_valid, busy;

   int   checks   = 0;
   int   failures = 0;
   exp_t q[$];
   logic [DW-1:0] sbp [LATENCY];
   int   ecyc   = 0;
   int   cyc_idx = 0;
   logic cyc_en = 1'b0;
   int   ptr    = 0;
   logic st_done = 1'b0, key_done = 1'b0;
   logic zero_next = 1'b0;

   sbox_share_sched #(
      .d       (D),
      .LATENCY (LATENCY)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .st_in_valid   (st_in_valid),
      .st_in_ready   (st_in_ready),
      .st_in_data    (st_in_data),
      .key_in_valid  (key_in_valid),
      .key_in_ready  (key_in_ready),
      .key_in_data   (key_in_data),
      .rnd_valid     (rnd_valid),
      .rnd_ready     (rnd_ready),
      .sb_en         (sb_en),
      .sb_in         (sb_in),
      .sb_out        (sb_out),
      .st_out_valid  (st_out_valid),
      .key_out_valid (key_out_valid),
      .out_data      (out_data),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // One clock cycle of stimulus plus model update
   task automatic step(input int p_st, input int p_key, input int p_rnd);
      logic gs, gk;
      logic [DW-1:0] exp_in;
      exp_t e;
      @(negedge clk);
      if (st_done)  st_in_valid  = 1'b0;
      if (key_done) key_in_valid = 1'b0;
      if (!st_in_valid && $urandom_range(99) < p_st) begin
         st_in_valid = 1'b1;
         st_in_data  = zero_next ? '0 : {$urandom, $urandom};
         zero_next   = 1'b0;
      end
      if (!key_in_valid && $urandom_range(99) < p_key) begin
         key_in_valid = 1'b1;
         key_in_data  = {$urandom, $urandom};
      end
      rnd_valid = ($urandom_range(99) < p_rnd);
      sb_out    = sbp[LATENCY-1] ^ MASKC;
      #1;
      gs = 1'b0;
      gk = 1'b0;
      if (rnd_valid) begin
         if (st_in_valid && key_in_valid) begin
`ifdef SBOX_SCHED_RR_EN
            gs  = (ptr == 0);
            gk  = (ptr == 1);
            ptr = 1 - ptr;
`else
            gk = 1'b1;
`endif
         end else begin
            gs = st_in_valid;
            gk = key_in_valid;
         end
      end
      exp_in = gk ? key_in_data : (gs ? st_in_data : '0);
      chk("rnd_ready",    DW'(rnd_ready),    DW'(rnd_valid));
      chk("sb_en",        DW'(sb_en),        DW'(rnd_valid));
      chk("st_in_ready",  DW'(st_in_ready),  DW'(gs));
      chk("key_in_ready", DW'(key_in_ready), DW'(gk));
      chk("sb_in",        sb_in,             exp_in);
      chk("busy",         DW'(busy),         DW'(q.size() != 0));
      if (gs || gk) begin
         e.owner = gk ? 1 : 0;
         e.data  = exp_in ^ MASKC;
         e.due   = ecyc + int'(LATENCY);
         q.push_back(e);
      end
      cyc_en  = rnd_valid;
      cyc_idx = ecyc;
      if (rnd_valid) begin
         for (int i = int'(LATENCY) - 1; i > 0; i--) sbp[i] = sbp[i-1];
         sbp[0] = exp_in;
         ecyc++;
      end
      st_done  = gs;
      key_done = gk;
   endtask

   // Mid-operation reset: everything in flight must vanish at once
   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b1;
      st_in_valid  = 1'b0;
      key_in_valid = 1'b0;
      rnd_valid    = 1'b0;
      st_done      = 1'b0;
      key_done     = 1'b0;
      cyc_en       = 1'b0;
      #1;
      chk("busy_async_reset",  DW'(busy),         '0);
      chk("st_ready_in_reset", DW'(st_in_ready),  '0);
      chk("key_ready_in_reset",DW'(key_in_ready), '0);
      q.delete();
      ptr = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: pops the scoreboard whenever a result pulse appears
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (st_out_valid && key_out_valid) begin
            chk("dual_pulse", 2'b11, 2'b01);
         end else if (st_out_valid || key_out_valid) begin
            chk("pulse_enabled", DW'(cyc_en), DW'(1'b1));
            if (q.size() == 0) begin
               chk("unexpected_pulse", DW'(1'b1), DW'(1'b0));
            end else begin
               e = q.pop_front();
               chk("result_owner", DW'(key_out_valid), DW'(e.owner));
               chk("out_data",     out_data,           e.data);
               chk("result_cycle", DW'(cyc_idx),       DW'(e.due));
            end
         end else if (cyc_en && q.size() != 0 && q[0].due == cyc_idx) begin
            e = q.pop_front();
            chk("missing_pulse", DW'(1'b0), DW'(1'b1));
         end
      end
   end

   initial begin
      rst          = 1'b1;
      st_in_valid  = 1'b0;
      key_in_valid = 1'b0;
      st_in_data   = '0;
      key_in_data  = '0;
      rnd_valid    = 1'b0;
      sb_out       = '0;
      for (int i = 0; i < int'(LATENCY); i++) sbp[i] = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_st_ready",  DW'(st_in_ready),   '0);
      chk("reset_key_ready", DW'(key_in_ready),  '0);
      chk("reset_sb_en",     DW'(sb_en),         '0);
      chk("reset_rnd_ready", DW'(rnd_ready),     '0);
      chk("reset_st_out",    DW'(st_out_valid),  '0);
      chk("reset_key_out",   DW'(key_out_valid), '0);
      chk("reset_busy",      DW'(busy),          '0);
      @(negedge clk);
      rst = 1'b0;

      // Single state request with all-zero shares, then drain
      zero_next = 1'b1;
      step(100, 0, 100);
      repeat (6) step(0, 0, 100);

      // Contention for several cycles
      repeat (6) step(100, 100, 100);
      repeat (12) step(0, 0, 100);

      // Two in flight, then a three-cycle randomness stall
      repeat (2) step(100, 0, 100);
      repeat (3) step(0, 0, 0);
      repeat (8) step(0, 0, 100);

      // Continuous state stream
      repeat (8) step(100, 0, 100);
      repeat (8) step(0, 0, 100);

      // Reset with results in flight; nothing may emerge afterwards
      repeat (3) step(100, 100, 100);
      do_reset();
      repeat (6) step(0, 0, 100);
      repeat (2) step(100, 0, 100);
      repeat (8) step(0, 0, 100);

      // Random mix
      repeat (500) step(60, 60, 70);
      repeat (16) step(0, 0, 100);
      @(negedge clk);
      #3;
      chk("scoreboard_drained", DW'(q.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
